tacho_capture: RTL and testbench
================================

TACHO_CAPTURE -- requirements
Module: tacho_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops on I_spd1, I_spd2 and I_load; legal range 2..4.
REQ-002 SHALL have ports, clock and reset first:
 I_clk  input  1  system clock, 25 MHz.
 I_reset_n  input  1  one clock; reset is asynchronous and active-low.
 I_spd1  input  1  tachometer channel 1, asynchronous to I_clk.
 I_spd2  input  1  tachometer channel 2, asynchronous to I_clk.
 I_enable  input  1  capture enable, level, active high.
 I_load  input  1  load pulse-counter command, positive edge valid, asynchronous.
 I_init_cnt  input  32  value loaded into the pulse counter.
 I_timeout  input  32  stall threshold in I_clk cycles; 0 disables stall detection.
 O_period  output  32  I_clk cycles between the last two I_spd1 rises.
 O_phase  output  32  I_clk cycles from the last I_spd1 rise to the following I_spd2 rise.
 O_dir  output  1  0 = spd1 leads spd2; 1 = spd2 leads spd1.
 O_pulse_cnt  output  32  up/down pulse count.
 O_valid  output  1  one-cycle strobe when O_period updates.
 O_stall  output  1  high while no I_spd1 rise has been seen for I_timeout cycles.

Function
REQ-003 SHALL pass I_spd1, I_spd2 and I_load through SYNC_STAGES flops plus one history flop; a rise event SHALL be last_sync=1 and history=0, and SHALL last exactly one cycle.
REQ-004 SHALL have states IDLE, WAIT_FIRST, MEASURE and STALLED.
REQ-005 IDLE->WAIT_FIRST when I_enable=1; any state->IDLE when I_enable=0, taking effect on the next clock edge.
REQ-006 WAIT_FIRST->MEASURE on the first spd1 rise event; the period counter SHALL be cleared to 0 and O_valid SHALL NOT assert.
REQ-007 In MEASURE, the period counter SHALL increment by 1 every cycle and saturate at 0xFFFFFFFF.
REQ-008 On an spd1 rise event in MEASURE: O_period <= counter+1 (saturating); counter <= 0; O_valid=1 for exactly one cycle, registered on the same edge as O_period.
REQ-009 Latency: if I_spd1 is first sampled high at clock edge N and SYNC_STAGES=2, O_valid and O_period SHALL be updated at edge N+2 and visible during cycle N+2..N+3.
REQ-010 MEASURE->STALLED when I_timeout!=0 and counter+1 >= I_timeout; on entry O_period <= 0 and O_stall <= 1, with no O_valid.
REQ-011 STALLED->MEASURE on an spd1 rise event: counter <= 0, O_stall <= 0, no O_valid, no period published.
REQ-012 On every spd1 rise event in WAIT_FIRST, MEASURE or STALLED, O_dir SHALL be set to the synchronized I_spd2 level at that edge.
REQ-013 On every such rise event, O_pulse_cnt SHALL be incremented if the newly sampled direction is 0 and decremented if it is 1, wrapping modulo 2^32.
REQ-014 Phase counter: cleared on each spd1 rise event, then increments each cycle, saturating.
REQ-015 On the first spd2 rise event after an spd1 rise event, O_phase SHALL be set to the phase counter + 1; later spd2 rise events before the next spd1 rise event SHALL be ignored.
REQ-016 If spd1 and spd2 rise events coincide, O_phase SHALL be set to 0 and O_dir to 1.
REQ-017 An I_load rise event SHALL set O_pulse_cnt <= I_init_cnt in any state, including IDLE.
REQ-018 If an I_load rise event and an spd1 rise event coincide, the load SHALL win and that edge SHALL NOT be counted; O_period/O_dir SHALL still update per REQ-008 and REQ-012.
REQ-019 On entry to IDLE: O_period, O_phase, O_stall, O_valid and the internal counters SHALL be 0; O_pulse_cnt and O_dir SHALL hold.
REQ-020 In IDLE, rise events on spd1 and spd2 SHALL be ignored.
REQ-021 A change of I_timeout mid-measurement SHALL take effect on the next cycle's compare.

Reset
REQ-022 While I_reset_n=0: state=IDLE; all synchronizer, history and counter flops 0; O_period=0, O_phase=0, O_dir=0, O_pulse_cnt=0, O_valid=0, O_stall=0.
REQ-023 Reset assertion mid-operation SHALL clear all state immediately, without waiting for I_clk.
REQ-024 After reset release, an input already high SHALL NOT produce a rise event until it has been seen low.

Verification
REQ-025 Enable=1, I_spd1 period 100 cycles, I_spd2 lagging by 25 cycles, 5 periods -> from the 2nd rise on: O_period=100, O_phase=25, O_dir=0, O_valid once per period; O_pulse_cnt=5.
REQ-026 Same waveform with I_spd2 leading by 25 cycles (spd1 lagging), I_init_cnt=10 loaded first -> O_dir=1, O_pulse_cnt=5 after 5 rises.
REQ-027 I_timeout=300, spd1 period 100 then spd1 stopped -> O_stall=1 and O_period=0 exactly 300 cycles after the last rise; the next rise clears O_stall with no O_valid, and the rise after it gives O_valid with a correct O_period.
REQ-028 I_load rising on the same synchronized edge as an spd1 rise, I_init_cnt=0x0000_0040 -> O_pulse_cnt=0x40 (that edge not counted), O_period updated.
REQ-029 O_pulse_cnt=0xFFFFFFFF, dir=0, one rise -> 0x00000000; O_pulse_cnt=0, dir=1, one rise -> 0xFFFFFFFF.
REQ-030 I_enable dropped mid-period, then I_reset_n pulsed low asynchronously mid-cycle -> O_period/O_phase/O_stall=0 after enable drop with O_pulse_cnt held; all outputs 0 immediately on reset.

Source files
------------

// File: rtl/tacho_capture.sv
// Dual-channel tachometer capture: period, phase, direction and up/down pulse count,
// with stall detection. All async inputs are synchronized and edge-detected locally.
module tacho_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_spd1,
  input  logic        I_spd2,
  input  logic        I_enable,
  input  logic        I_load,
  input  logic [31:0] I_init_cnt,
  input  logic [31:0] I_timeout,
  output logic [31:0] O_period,
  output logic [31:0] O_phase,
  output logic        O_dir,
  output logic [31:0] O_pulse_cnt,
  output logic        O_valid,
  output logic        O_stall
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, STALLED} state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Channel index: 0 = spd1, 1 = spd2, 2 = load
  logic [2:0]                  async_in;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0]      fill_q;
  logic [2:0]                  hist_q;
  logic [2:0]                  armed_q;
  logic [2:0]                  sync_last;
  logic [2:0]                  rise;
  logic                        primed;

  assign async_in = {I_load, I_spd2, I_spd1};
  assign primed   = fill_q[SYNC_STAGES-1];

  always_comb begin
    for (int ch = 0; ch < 3; ch++) sync_last[ch] = sync_q[ch][SYNC_STAGES-1];
  end

  // A channel arms only once a genuine low sample has reached the chain end,
  // so a line already high at reset release never looks like a rise.
  assign rise = armed_q & sync_last & ~hist_q;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= '0;
      armed_q <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++)
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], async_in[ch]};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= sync_last;
      armed_q <= armed_q | ({3{primed}} & ~sync_last);
    end
  end

  logic s1_rise, s2_rise, ld_rise, s2_lvl;
  assign s1_rise = rise[0];
  assign s2_rise = rise[1];
  assign ld_rise = rise[2];
  assign s2_lvl  = sync_last[1];

  state_e      state_q, state_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic        phase_arm_q, phase_arm_d;
  logic [31:0] period_q, period_d;
  logic [31:0] phase_q, phase_d;
  logic        dir_q, dir_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        valid_q, valid_d;
  logic        stall_q, stall_d;
  logic        stall_hit;

  assign stall_hit = (I_timeout != 32'd0) && (sat_inc(period_cnt_q) >= I_timeout);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!I_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = WAIT_FIRST;
        WAIT_FIRST: if (s1_rise) state_d = MEASURE;
        MEASURE:    if (!s1_rise && stall_hit) state_d = STALLED;
        STALLED:    if (s1_rise) state_d = MEASURE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    period_cnt_d = period_cnt_q;
    phase_cnt_d  = phase_cnt_q;
    phase_arm_d  = phase_arm_q;
    period_d     = period_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    pcnt_d       = pcnt_q;
    valid_d      = 1'b0;
    stall_d      = stall_q;
    if (!I_enable) begin
      period_cnt_d = '0;
      phase_cnt_d  = '0;
      phase_arm_d  = 1'b0;
      period_d     = '0;
      phase_d      = '0;
      stall_d      = 1'b0;
    end else if (state_q != IDLE) begin
      if (state_q == MEASURE || state_q == STALLED) begin
        period_cnt_d = sat_inc(period_cnt_q);
        phase_cnt_d  = sat_inc(phase_cnt_q);
      end
      if (s2_rise && phase_arm_q) begin
        phase_d     = sat_inc(phase_cnt_q);
        phase_arm_d = 1'b0;
      end
      if (s1_rise) begin
        dir_d        = s2_lvl;
        pcnt_d       = s2_lvl ? pcnt_q - 32'd1 : pcnt_q + 32'd1;
        period_cnt_d = '0;
        phase_cnt_d  = '0;
        phase_arm_d  = 1'b1;
        // Coincident edges: zero phase, and this spd1 rise has already been matched
        if (s2_rise) begin
          phase_d     = '0;
          phase_arm_d = 1'b0;
        end
        if (state_q == MEASURE) begin
          period_d = sat_inc(period_cnt_q);
          valid_d  = 1'b1;
        end
        if (state_q == STALLED) stall_d = 1'b0;
      end else if (state_q == MEASURE && stall_hit) begin
        period_d = '0;
        stall_d  = 1'b1;
      end
    end
    if (ld_rise) pcnt_d = I_init_cnt;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      period_cnt_q <= '0;
      phase_cnt_q  <= '0;
      phase_arm_q  <= 1'b0;
      period_q     <= '0;
      phase_q      <= '0;
      dir_q        <= 1'b0;
      pcnt_q       <= '0;
      valid_q      <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      phase_arm_q  <= phase_arm_d;
      period_q     <= period_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      pcnt_q       <= pcnt_d;
      valid_q      <= valid_d;
      stall_q      <= stall_d;
    end
  end

  assign O_period    = period_q;
  assign O_phase     = phase_q;
  assign O_dir       = dir_q;
  assign O_pulse_cnt = pcnt_q;
  assign O_valid     = valid_q;
  assign O_stall     = stall_q;

endmodule

// File: tb/tb_tacho_capture.sv
// Directed bench for tacho_capture: quadrature waveforms, stall, load collision,
// pulse-count wrap, enable drop and async reset.
module tb_tacho_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spd1, spd2, enable, load;
  logic [31:0] init_cnt, timeout;
  logic [31:0] period, phase, pcnt;
  logic        dir, valid, stall;

  int checks = 0;
  int errors = 0;

  tacho_capture #(.SYNC_STAGES(2)) dut (
    .I_clk      (clk),
    .I_reset_n  (rst_n),
    .I_spd1     (spd1),
    .I_spd2     (spd2),
    .I_enable   (enable),
    .I_load     (load),
    .I_init_cnt (init_cnt),
    .I_timeout  (timeout),
    .O_period   (period),
    .O_phase    (phase),
    .O_dir      (dir),
    .O_pulse_cnt(pcnt),
    .O_valid    (valid),
    .O_stall    (stall)
  );

  always #20 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Square wave: 5 periods of 100 cycles, 50% duty, starting at t=0
  function automatic bit sq(input int t);
    return (t >= 0) && (t < 500) && ((t % 100) < 50);
  endfunction

  task automatic wave(input int s1off, input int s2off, input int len, input logic edir,
                      input logic [31:0] pc0, input logic [31:0] eph);
    int nval;
    int d;
    int k;
    nval = 0;
    for (int t = 0; t < len; t++) begin
      spd1 = sq(t - s1off);
      spd2 = sq(t - s2off);
      tick(1);
      if (valid) nval++;
      d = t - 2 - s1off;
      if (d >= 0 && (d % 100) == 0 && d < 500) begin
        k = d / 100;
        chk("valid_at_rise", 32'(valid), (k >= 1) ? 32'd1 : 32'd0);
        if (k >= 1) chk("period", period, 32'd100);
        chk("dir", 32'(dir), 32'(edir));
        chk("pulse_cnt", pcnt, edir ? pc0 - 32'(k + 1) : pc0 + 32'(k + 1));
      end
      d = t - 2 - s2off;
      if (d >= 0 && (s2off + d) > s1off && (d % 100) == 0 && d < 500)
        chk("phase", phase, eph);
    end
    chk("valid_count", 32'(nval), 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; spd1 = 1'b0; spd2 = 1'b0; enable = 1'b0; load = 1'b0;
    init_cnt = '0; timeout = '0;
    tick(2);
    chk("rst_period", period, 32'd0);
    chk("rst_phase", phase, 32'd0);
    chk("rst_pcnt", pcnt, 32'd0);
    chk("rst_flags", {28'd0, dir, valid, stall, 1'b0}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    enable = 1'b1;
    tick(2);

    // spd2 lags spd1 by 25
    wave(0, 25, 505, 1'b0, 32'd0, 32'd25);

    enable = 1'b0;
    tick(1);
    chk("idle_period", period, 32'd0);
    chk("idle_phase", phase, 32'd0);
    chk("idle_pcnt_hold", pcnt, 32'd5);
    enable = 1'b1;
    tick(2);
    init_cnt = 32'd10; load = 1'b1;
    tick(4);
    chk("load_10", pcnt, 32'd10);
    load = 1'b0;
    tick(4);

    // spd2 leads spd1 by 25
    wave(25, 0, 530, 1'b1, 32'd10, 32'd75);

    // Stall, recovery, then load colliding with an spd1 rise
    enable = 1'b0; tick(1); enable = 1'b1; timeout = 32'd300; tick(2);
    init_cnt = 32'h40;
    for (int t = 0; t < 850; t++) begin
      spd1 = (t < 300 && (t % 100) < 50) || (t >= 600 && t < 800 && ((t - 600) % 100) < 50)
             || (t >= 800 && t < 830);
      load = (t >= 800 && t < 830);
      spd2 = 1'b0;
      tick(1);
      case (t)
        202: begin chk("pre_stall_valid", 32'(valid), 32'd1); chk("pre_stall_period", period, 32'd100); end
        501: chk("stall_early", 32'(stall), 32'd0);
        502: begin
          chk("stall_set", 32'(stall), 32'd1);
          chk("stall_period", period, 32'd0);
          chk("stall_valid", 32'(valid), 32'd0);
        end
        602: begin
          chk("unstall", 32'(stall), 32'd0);
          chk("unstall_valid", 32'(valid), 32'd0);
          chk("unstall_period", period, 32'd0);
        end
        702: begin chk("resume_valid", 32'(valid), 32'd1); chk("resume_period", period, 32'd100); end
        802: begin
          chk("coll_valid", 32'(valid), 32'd1);
          chk("coll_period", period, 32'd100);
          chk("coll_pcnt", pcnt, 32'h40);
          chk("coll_dir", 32'(dir), 32'd0);
        end
        default: ;
      endcase
    end
    timeout = 32'd0;

    // Pulse-count wrap in both directions
    init_cnt = 32'hFFFF_FFFF; load = 1'b1; tick(4);
    chk("load_max", pcnt, 32'hFFFF_FFFF);
    load = 1'b0; tick(4);
    spd1 = 1'b1; tick(3);
    chk("wrap_up", pcnt, 32'd0);
    chk("wrap_up_dir", 32'(dir), 32'd0);
    tick(5); spd1 = 1'b0; tick(5);
    spd2 = 1'b1; tick(5);
    spd1 = 1'b1; tick(3);
    chk("wrap_down", pcnt, 32'hFFFF_FFFF);
    chk("wrap_down_dir", 32'(dir), 32'd1);
    tick(5);

    // Enable drop mid-period
    enable = 1'b0;
    tick(1);
    chk("drop_period", period, 32'd0);
    chk("drop_phase", phase, 32'd0);
    chk("drop_stall_valid", {30'd0, stall, valid}, 32'd0);
    chk("drop_pcnt_hold", pcnt, 32'hFFFF_FFFF);
    chk("drop_dir_hold", 32'(dir), 32'd1);

    // Async reset mid-cycle, spd1 held high through it
    enable = 1'b1; spd2 = 1'b0;
    tick(1);
    #10;
    rst_n = 1'b0;
    #1;
    chk("async_pcnt", pcnt, 32'd0);
    chk("async_dir", 32'(dir), 32'd0);
    chk("async_period", period, 32'd0);
    #3;
    rst_n = 1'b1;
    tick(10);
    chk("no_rise_after_reset", pcnt, 32'd0);
    spd1 = 1'b0;
    tick(5);
    for (int t = 0; t < 60; t++) begin
      spd1 = (t < 25) || (t >= 50);
      tick(1);
      if (t == 2) begin
        chk("first_rise_pcnt", pcnt, 32'd1);
        chk("first_rise_novalid", 32'(valid), 32'd0);
      end
      if (t == 52) begin
        chk("p50_valid", 32'(valid), 32'd1);
        chk("p50_period", period, 32'd50);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
